// File: rtl/ref_fifo_pkg.sv
// Shared helpers for ref_param_fifo: width derivation and parameter legality.
package ref_fifo_pkg;

  localparam int MIN_DEPTH = 2;
  localparam int MAX_DEPTH = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  // Level must represent DEPTH itself, hence DEPTH+1 codes.
  function automatic int lvl_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int depth, input int thresh);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0) &&
           (thresh >= 1) && (thresh <= depth);
  endfunction

endpackage

// File: rtl/ref_fifo_ram.sv
// DEPTH x DATA_WIDTH register array, one write port and an asynchronous read port.
module ref_fifo_ram
  import ref_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ref_param_fifo.sv
// Registered-flag FIFO of DEPTH words; every flag is a flop, 1-cycle fill latency, no pass-through when full.
// Optional synchronous flush port enabled by defining REF_FIFO_FLUSH_EN.
module ref_param_fifo
  import ref_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 4,
  parameter  int AFULL_THRESH = DEPTH - 1,
  localparam int LVL_W        = lvl_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_src_rdy,
  output logic                  in_dst_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_afull,
  output logic                  out_src_rdy,
  input  logic                  out_dst_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LVL_W-1:0]      level
`ifdef REF_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int               PTR_W    = ptr_w(DEPTH);
  localparam logic [LVL_W-1:0] L_DEPTH  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] L_THRESH = LVL_W'(AFULL_THRESH);

  if (!params_ok(DEPTH, AFULL_THRESH)) begin : g_bad_params
    $error("ref_param_fifo: illegal DEPTH=%0d or AFULL_THRESH=%0d", DEPTH, AFULL_THRESH);
  end

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  // Internal ready copies feed the enables so the port flops only load the outputs.
  logic             r_in_rdy;
  logic             r_out_rdy;
  logic             r_in_dst_rdy;
  logic             r_out_src_rdy;
  logic             r_afull;

  logic             w_in_en;
  logic             w_out_en;
  logic [LVL_W-1:0] w_level_nxt;

  assign w_in_en  = in_src_rdy & r_in_rdy;
  assign w_out_en = r_out_rdy & out_dst_rdy;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_in_en, w_out_en})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_in_rdy      <= 1'b0;
      r_in_dst_rdy  <= 1'b0;
      r_out_rdy     <= 1'b0;
      r_out_src_rdy <= 1'b0;
      r_afull       <= 1'b0;
    end
`ifdef REF_FIFO_FLUSH_EN
    else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_in_rdy      <= 1'b1;
      r_in_dst_rdy  <= 1'b1;
      r_out_rdy     <= 1'b0;
      r_out_src_rdy <= 1'b0;
      r_afull       <= 1'b0;
    end
`endif
    else begin
      if (w_in_en)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_out_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level       <= w_level_nxt;
      r_in_rdy      <= (w_level_nxt < L_DEPTH);
      r_in_dst_rdy  <= (w_level_nxt < L_DEPTH);
      r_out_rdy     <= (w_level_nxt != '0);
      r_out_src_rdy <= (w_level_nxt != '0);
      r_afull       <= (w_level_nxt >= L_THRESH);
    end
  end

  // Writing whenever there is room keeps in_src_rdy off the storage enable.
  ref_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PTR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (r_in_rdy),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  assign in_dst_rdy  = r_in_dst_rdy;
  assign out_src_rdy = r_out_src_rdy;
  assign in_afull    = r_afull;
  assign level       = r_level;

endmodule

// File: tb/tb_ref_param_fifo.sv
// Queue-model bench for ref_param_fifo (DEPTH=4) with directed phases and literal pins.
module tb_ref_param_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int THR   = DEPTH - 1;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_src_rdy = 1'b0;
  logic          out_dst_rdy = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_dst_rdy;
  logic          in_afull;
  logic          out_src_rdy;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
`ifdef REF_FIFO_FLUSH_EN
  logic          flush = 1'b0;
`endif

  ref_param_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_src_rdy  (in_src_rdy),
    .in_dst_rdy  (in_dst_rdy),
    .in_data     (in_data),
    .in_afull    (in_afull),
    .out_src_rdy (out_src_rdy),
    .out_dst_rdy (out_dst_rdy),
    .out_data    (out_data),
    .level       (level)
`ifdef REF_FIFO_FLUSH_EN
    ,
    .flush       (flush)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of words plus "last edge was reset" (which holds in_dst_rdy low one cycle).
  logic [DW-1:0] q[$];
  bit            m_rst = 1'b1;

  always @(posedge clk) begin : model
    bit ie, oe;
    ie = in_src_rdy && !m_rst && (q.size() < DEPTH);
    oe = out_dst_rdy && (q.size() != 0);
    if (rst) begin
      q.delete();
      m_rst = 1'b1;
    end
`ifdef REF_FIFO_FLUSH_EN
    else if (flush) begin
      q.delete();
      m_rst = 1'b0;
    end
`endif
    else begin
      if (oe) void'(q.pop_front());
      if (ie) q.push_back(in_data);
      m_rst = 1'b0;
    end
    #2;
    chk("m_in_dst_rdy", in_dst_rdy, (!m_rst && q.size() < DEPTH));
    chk("m_out_src_rdy", out_src_rdy, (q.size() != 0));
    chk("m_in_afull", in_afull, (q.size() >= THR));
    chk("m_level", level, q.size());
    if (q.size() != 0) chk("m_out_data", out_data, q[0]);
  end

  // Words actually handed to the consumer, in order.
  logic [DW-1:0] got[$];
  always @(negedge clk) begin
    bit busy;
    busy = rst;
`ifdef REF_FIFO_FLUSH_EN
    busy = busy || flush;
`endif
    if (!busy && out_src_rdy === 1'b1 && out_dst_rdy === 1'b1) got.push_back(out_data);
  end

  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  task automatic drain();
    in_src_rdy  = 1'b0;
    out_dst_rdy = 1'b1;
    for (int k = 0; k < 40 && level != 0; k++) tick();
    chk("drain_empty", level, 0);
    out_dst_rdy = 1'b0;
  endtask

  logic [DW-1:0] vals[4];
  logic [DW-1:0] sent[$];
  bit            acc;
  int            widx;
  int            cyc;
  logic [DW-1:0] dcnt;

  initial begin
    // Reset held for three edges
    repeat (3) tick();
    chk("rst_in_dst_rdy", in_dst_rdy, 0);
    chk("rst_out_src_rdy", out_src_rdy, 0);
    chk("rst_afull", in_afull, 0);
    chk("rst_level", level, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_dst_rdy", in_dst_rdy, 1);
    chk("post_rst_level", level, 0);

    // Fill to full, then a fifth push that must be ignored
    for (int i = 0; i < 4; i++) begin
      in_src_rdy = 1'b1;
      in_data    = (i + 1) * 32'h11;
      tick();
      chk("fill_level", level, i + 1);
      chk("fill_afull", in_afull, (i >= 2));
      chk("fill_in_dst_rdy", in_dst_rdy, (i < 3));
    end
    in_data = 32'h99;
    tick();
    chk("fifth_push_level", level, 4);
    chk("full_out_data", out_data, 32'h11);

    // Alternate read/write from full so both pointers wrap
    vals = '{32'h55, 32'h66, 32'h77, 32'h88};
    widx = 0;
    cyc  = 0;
    while (widx < 4 && cyc < 40) begin
      in_src_rdy  = 1'b1;
      in_data     = vals[widx];
      out_dst_rdy = (cyc % 2 == 0);
      acc = in_dst_rdy;
      tick();
      if (acc) widx++;
      cyc++;
    end
    chk("wrap_writes_done", widx, 4);
    drain();
    chk("wrap_count", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("wrap_order", got[k], (k + 1) * 32'h11);
    got.delete();

    // Streaming: one word per clock, level stays at 1
    in_src_rdy  = 1'b1;
    out_dst_rdy = 1'b1;
    dcnt = 32'h1000;
    in_data = dcnt;
    for (int i = 0; i < 100; i++) begin
      acc = in_dst_rdy;
      tick();
      if (acc) begin
        dcnt++;
        in_data = dcnt;
      end
      chk("stream_level", level, 1);
    end
    drain();
    chk("stream_count", got.size(), 100);
    for (int k = 0; k < 100 && k < got.size(); k++) chk("stream_order", got[k], 32'h1000 + k);
    got.delete();

    // Random backpressure on both sides
    dcnt = 32'h0002_0000;
    for (int i = 0; i < 3000; i++) begin
      in_src_rdy  = ($urandom_range(0, 3) != 0);
      out_dst_rdy = ($urandom_range(0, 2) != 0);
      in_data     = dcnt;
      acc = in_dst_rdy && in_src_rdy;
      tick();
      if (acc) begin
        sent.push_back(in_data);
        dcnt++;
      end
    end
    drain();
    chk("rand_count", got.size(), sent.size());
    for (int k = 0; k < sent.size() && k < got.size(); k++) chk("rand_order", got[k], sent[k]);
    got.delete();

    // Reset mid-operation discards held words
    in_src_rdy = 1'b1;
    in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    chk("mid_level", level, 2);
    in_src_rdy = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_out_src_rdy", out_src_rdy, 0);
    rst = 1'b0;
    tick();
    in_src_rdy = 1'b1;
    in_data = 32'hAB;
    tick();
    in_src_rdy = 1'b0;
    chk("mid_first_out", out_data, 32'hAB);
    drain();
    chk("mid_count", got.size(), 1);
    if (got.size() != 0) chk("mid_word", got[0], 32'hAB);
    got.delete();

`ifdef REF_FIFO_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      in_src_rdy = 1'b1;
      in_data = 32'hC1 + i;
      tick();
    end
    chk("flush_pre_level", level, 3);
    flush = 1'b1;
    in_data = 32'hDEAD;
    tick();
    flush = 1'b0;
    in_src_rdy = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_out_src_rdy", out_src_rdy, 0);
    chk("flush_in_dst_rdy", in_dst_rdy, 1);
    in_src_rdy = 1'b1;
    in_data = 32'hBEEF;
    tick();
    drain();
    chk("flush_count", got.size(), 1);
    if (got.size() != 0) chk("flush_word", got[0], 32'hBEEF);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
